// File: rtl/packet_transmitter.sv
// Output-port transmitter: drains one per-port packet buffer onto the byte-wide router link.
// Build option PKT_TX_CRC_REGEN_EN replaces the stored CRC byte with an XOR of SRC, DST, SIZE and DATA.
module packet_transmitter #(
    parameter int PTR_SZ = 4,
    parameter int UWIDTH = 8
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              pkt_avail_i,
    input  logic [UWIDTH-1:0] rdata_i,
    output logic [PTR_SZ-1:0] raddr_o,
    output logic              rinc_o,
    input  logic              stop_packet_send,
    output logic              packet_valid_o,
    output logic [UWIDTH-1:0] pdata_o,
    output logic              busy_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SRC  = 3'd1,
        DST  = 3'd2,
        SIZE = 3'd3,
        DATA = 3'd4,
        CRC  = 3'd5,
        GAP  = 3'd6
    } state_t;

    state_t     state;
    logic [2:0] data_cnt;
`ifdef PKT_TX_CRC_REGEN_EN
    logic [UWIDTH-1:0] crc_acc;
`endif

    assign busy_o = (state != IDLE);

    always_ff @(posedge clk1) begin
        if (rst) begin
            state          <= IDLE;
            raddr_o        <= '0;
            rinc_o         <= 1'b0;
            packet_valid_o <= 1'b0;
            pdata_o        <= '0;
            data_cnt       <= '0;
`ifdef PKT_TX_CRC_REGEN_EN
            crc_acc        <= '0;
`endif
        end else begin
            rinc_o <= 1'b0;
            case (state)
                IDLE: begin
                    packet_valid_o <= 1'b0;
`ifdef PKT_TX_CRC_REGEN_EN
                    crc_acc        <= '0;
`endif
                    // Backpressure only gates the start; a started packet always runs to its CRC.
                    if (pkt_avail_i && !stop_packet_send) state <= SRC;
                end
                SRC, DST, SIZE, DATA, CRC: begin
                    pdata_o        <= rdata_i;
                    packet_valid_o <= 1'b1;
                    raddr_o        <= raddr_o + PTR_SZ'(1);
`ifdef PKT_TX_CRC_REGEN_EN
                    if (state != CRC) crc_acc <= crc_acc ^ rdata_i;
`endif
                    case (state)
                        SRC: state <= DST;
                        DST: state <= SIZE;
                        SIZE: begin
                            data_cnt <= rdata_i[2:0];
                            state    <= (rdata_i[2:0] != 3'd0) ? DATA : CRC;
                        end
                        DATA: begin
                            data_cnt <= data_cnt - 3'd1;
                            if (data_cnt == 3'd1) state <= CRC;
                        end
                        default: begin
                            rinc_o <= 1'b1;
                            state  <= GAP;
`ifdef PKT_TX_CRC_REGEN_EN
                            pdata_o <= crc_acc;
`endif
                        end
                    endcase
                end
                GAP: begin
                    // One dead cycle lets the buffer retire the packet before IDLE looks at pkt_avail_i.
                    packet_valid_o <= 1'b0;
                    state          <= IDLE;
                end
                default: begin
                    packet_valid_o <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_packet_transmitter.sv
// Bench for packet_transmitter: the bench owns the packet buffer and predicts the link byte stream.
`timescale 1ns/1ps
module tb_packet_transmitter;
  localparam int PTR_SZ = 4;
  localparam int UWIDTH = 8;
  localparam int DEPTH  = 16;

  logic              clk1 = 1'b0;
  logic              rst = 1'b1;
  logic              pkt_avail_i;
  logic [UWIDTH-1:0] rdata_i;
  logic [PTR_SZ-1:0] raddr_o;
  logic              rinc_o;
  logic              stop_packet_send = 1'b0;
  logic              packet_valid_o;
  logic [UWIDTH-1:0] pdata_o;
  logic              busy_o;

  logic [7:0] mem [DEPTH];
  int loaded_cnt = 0;
  int released_cnt = 0;
  int wptr = 0;
  int pkt_total = 0;
  int total = 0;
  int bad = 0;

  logic [7:0] exp_q[$];
  bit         exp_last_q[$];
  logic [7:0] seen_q[$];
  int         rinc_seen = 0;
  int         gap_cnt = 0;
  int         last_gap = 0;
  bit         in_pkt = 0;
  bit         had_pkt = 0;
  logic [7:0] last_pd = 8'h00;
  logic       stop_h1 = 0, stop_h2 = 0, avail_h1 = 0, avail_h2 = 0;

  packet_transmitter #(.PTR_SZ(PTR_SZ), .UWIDTH(UWIDTH)) dut (
    .clk1(clk1),
    .rst(rst),
    .pkt_avail_i(pkt_avail_i),
    .rdata_i(rdata_i),
    .raddr_o(raddr_o),
    .rinc_o(rinc_o),
    .stop_packet_send(stop_packet_send),
    .packet_valid_o(packet_valid_o),
    .pdata_o(pdata_o),
    .busy_o(busy_o)
  );

  // clock / buffer model
  always #5 clk1 = ~clk1;
  assign rdata_i = mem[raddr_o];
  assign pkt_avail_i = (loaded_cnt != released_cnt);

  always @(posedge clk1) begin
    stop_h2 = stop_h1;
    stop_h1 = stop_packet_send;
    avail_h2 = avail_h1;
    avail_h1 = pkt_avail_i;
    if (!rst && rinc_o) released_cnt <= released_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // scoreboard: every link cycle is compared against the predicted byte stream
  always @(negedge clk1) begin : compare
    logic [7:0] e;
    bit         l;
    if (rst) begin
      exp_q.delete();
      exp_last_q.delete();
      in_pkt = 0;
      had_pkt = 0;
      gap_cnt = 0;
      last_pd = 8'h00;
    end else if (packet_valid_o) begin
      if (!in_pkt) begin
        check("start_stop_low", 32'(stop_h2), 0);
        check("start_avail", 32'(avail_h2), 1);
        if (had_pkt) begin
          check("gap_min2", 32'(gap_cnt >= 2), 1);
          last_gap = gap_cnt;
        end
        in_pkt = 1;
        had_pkt = 1;
      end
      gap_cnt = 0;
      check("busy_in_pkt", 32'(busy_o), 1);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_byte: got 0x%0h, nothing pending", pdata_o);
        in_pkt = 0;
      end else begin
        e = exp_q.pop_front();
        l = exp_last_q.pop_front();
        check("pdata", 32'(pdata_o), 32'(e));
        check("rinc", 32'(rinc_o), 32'(l));
        if (l) in_pkt = 0;
      end
      seen_q.push_back(pdata_o);
      last_pd = pdata_o;
      if (rinc_o) rinc_seen++;
    end else begin
      if (in_pkt) begin
        total++;
        bad++;
        $display("FAIL contiguity: valid dropped with %0d bytes pending", exp_q.size());
        in_pkt = 0;
      end
      check("rinc_idle", 32'(rinc_o), 0);
      check("pdata_hold", 32'(pdata_o), 32'(last_pd));
      gap_cnt++;
    end
  end

  // driver tasks
  task automatic put(input logic [7:0] stored, input logic [7:0] expect_b, input bit last);
    mem[wptr] = stored;
    exp_q.push_back(expect_b);
    exp_last_q.push_back(last);
    wptr = (wptr + 1) % DEPTH;
  endtask

  task automatic load_pkt(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] size,
                          input logic [63:0] data, input logic [7:0] crc);
    int n;
    logic [7:0] acc;
    logic [7:0] b;
    n = int'(size[2:0]);
    acc = src ^ dst ^ size;
    put(src, src, 0);
    put(dst, dst, 0);
    put(size, size, 0);
    for (int i = 0; i < n; i++) begin
      b = data[8*i +: 8];
      acc = acc ^ b;
      put(b, b, 0);
    end
`ifdef PKT_TX_CRC_REGEN_EN
    put(crc, acc, 1);
`else
    put(crc, crc, 1);
`endif
    pkt_total++;
    loaded_cnt++;
  endtask

  task automatic rand_pkt(input int n);
    logic [7:0] size;
    size = 8'($urandom_range(0, 255));
    size[2:0] = 3'(n);
    load_pkt(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), size,
             {32'($urandom), 32'($urandom)}, 8'($urandom_range(0, 255)));
  endtask

  task automatic drain(input string name, input bit rnd_stop);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || busy_o || pkt_avail_i) && cyc < 400) begin
      @(posedge clk1);
      #2;
      cyc++;
      if (rnd_stop) stop_packet_send = ($urandom_range(0, 3) == 0);
    end
    stop_packet_send = 1'b0;
    if (cyc >= 400) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: %0d bytes still pending after %0d cycles", name, exp_q.size(), cyc);
    end
    @(negedge clk1);
    #1;
    check({name, "_raddr_end"}, 32'(raddr_o), 32'(wptr));
    check({name, "_rinc_count"}, 32'(rinc_seen), 32'(pkt_total));
  endtask

  logic [7:0] pin_a [6];
  logic [7:0] pin_b [4];

  initial begin : stim
    int cyc;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
    pin_a = '{8'h01, 8'h05, 8'h02, 8'hAA, 8'hBB,
`ifdef PKT_TX_CRC_REGEN_EN
              8'h17};
`else
              8'h3D};
`endif
    pin_b = '{8'h01, 8'h80, 8'h00, 8'h81};

    // reset state
    repeat (2) @(posedge clk1);
    @(negedge clk1);
    #1;
    check("rst_valid", 32'(packet_valid_o), 0);
    check("rst_raddr", 32'(raddr_o), 0);
    check("rst_rinc", 32'(rinc_o), 0);
    check("rst_pdata", 32'(pdata_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    @(posedge clk1);
    #2;
    rst = 1'b0;

    // packet A, literal byte sequence
    seen_q.delete();
`ifdef PKT_TX_CRC_REGEN_EN
    load_pkt(8'h01, 8'h05, 8'h02, 64'hBBAA, 8'h00);
`else
    load_pkt(8'h01, 8'h05, 8'h02, 64'hBBAA, 8'h3D);
`endif
    drain("pkt_a", 0);
    check("pkt_a_len", 32'(seen_q.size()), 6);
    for (int i = 0; i < 6; i++)
      if (i < seen_q.size()) check("pkt_a_lit", 32'(seen_q[i]), 32'(pin_a[i]));
    check("pkt_a_raddr_lit", 32'(raddr_o), 6);
    check("pkt_a_rinc_lit", 32'(rinc_seen), 1);

    // packet B, SIZE=0
    seen_q.delete();
    load_pkt(8'h01, 8'h80, 8'h00, 64'h0, 8'h81);
    drain("pkt_b", 0);
    check("pkt_b_len", 32'(seen_q.size()), 4);
    for (int i = 0; i < 4; i++)
      if (i < seen_q.size()) check("pkt_b_lit", 32'(seen_q[i]), 32'(pin_b[i]));
    check("pkt_b_raddr_lit", 32'(raddr_o), 10);

    // packet C held by stop_packet_send, then released
    @(posedge clk1);
    #2;
    stop_packet_send = 1'b1;
    load_pkt(8'h02, 8'h03, 8'h00, 64'h0, 8'h01);
    repeat (6) begin
      @(negedge clk1);
      #1;
      check("stop_hold", 32'(packet_valid_o), 0);
    end
    @(posedge clk1);
    #2;
    stop_packet_send = 1'b0;
    @(negedge clk1);
    @(negedge clk1);
    #1;
    check("start_lat_idle", 32'(packet_valid_o), 0);
    @(negedge clk1);
    #1;
    check("start_lat_first", 32'(packet_valid_o), 1);
    drain("pkt_c", 0);
    check("pkt_c_raddr_lit", 32'(raddr_o), 14);

    // packet D wraps the read pointer; stop raised during DATA must be ignored
    seen_q.delete();
    load_pkt(8'h03, 8'h04, 8'h03, 64'h332211, 8'h04);
    cyc = 0;
    while (seen_q.size() < 4 && cyc < 100) begin
      @(negedge clk1);
      #1;
      cyc++;
    end
    check("pkt_d_in_data", 32'(seen_q.size() >= 4), 1);
    stop_packet_send = 1'b1;
    drain("pkt_d", 0);
    check("pkt_d_raddr_lit", 32'(raddr_o), 5);
    check("pkt_d_len", 32'(seen_q.size()), 7);

    // back-to-back packets with pkt_avail_i held high
    @(posedge clk1);
    #2;
    rand_pkt($urandom_range(0, 3));
    rand_pkt($urandom_range(0, 3));
    drain("b2b", 0);
    check("b2b_gap_lit", 32'(last_gap), 2);

    // randomized traffic with random backpressure
    for (int it = 0; it < 25; it++) begin
      @(posedge clk1);
      #2;
      if ($urandom_range(0, 1) == 0) begin
        rand_pkt($urandom_range(0, 7));
      end else begin
        rand_pkt($urandom_range(0, 3));
        rand_pkt($urandom_range(0, 3));
      end
      drain("rand", 1);
    end

    // reset during the second DATA byte abandons the packet
    @(posedge clk1);
    #2;
    seen_q.delete();
    rand_pkt(5);
    cyc = 0;
    while (seen_q.size() < 5 && cyc < 100) begin
      @(negedge clk1);
      #1;
      cyc++;
    end
    check("abort_reached_data", 32'(seen_q.size()), 5);
    rst = 1'b1;
    pkt_total--;
    @(negedge clk1);
    #1;
    check("abort_valid", 32'(packet_valid_o), 0);
    check("abort_raddr", 32'(raddr_o), 0);
    check("abort_rinc", 32'(rinc_o), 0);
    check("abort_busy", 32'(busy_o), 0);
    check("abort_rinc_count", 32'(rinc_seen), 32'(pkt_total));
    wptr = 0;
    loaded_cnt = released_cnt;
    rst = 1'b0;

    // recovery after abort
    @(posedge clk1);
    #2;
    rand_pkt($urandom_range(0, 7));
    drain("recover", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
